// File: rtl/alu_share_arbiter.sv
// Shared ALU arbiter: several requesters take turns on one combinational ALU.
// Grants are round-robin. The ALU result is held in a single output register
// that has valid/ready handshaking, so a new result can be loaded in the same
// cycle the consumer drains the old one.

package rv32i_types_pkg;
    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SLL  = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLTU = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_OR   = 4'd9,
        ALU_AND  = 4'd10
    } ALU_op_enum;
endpackage

// Purely combinational ALU. Shift amounts come from the low log2(width) bits
// of B, as in RV32I. ALU_NONE and any unassigned encoding produce zero.
module alu #(
    parameter int DATA_WIDTH = 32
) (
    input  rv32i_types_pkg::ALU_op_enum op_i,
    input  logic [DATA_WIDTH-1:0]       a_i,
    input  logic [DATA_WIDTH-1:0]       b_i,
    output logic [DATA_WIDTH-1:0]       f_o
);
    import rv32i_types_pkg::*;

    localparam int SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    // Decode the operation and compute the result.
    always_comb begin
        f_o = '0;
        case (op_i)
            ALU_ADD:  f_o = a_i + b_i;
            ALU_SUB:  f_o = a_i - b_i;
            ALU_SLL:  f_o = a_i << shamt;
            ALU_SLT:  f_o = DATA_WIDTH'($signed(a_i) < $signed(b_i));
            ALU_SLTU: f_o = DATA_WIDTH'(a_i < b_i);
            ALU_XOR:  f_o = a_i ^ b_i;
            ALU_SRL:  f_o = a_i >> shamt;
            ALU_SRA:  f_o = $signed(a_i) >>> shamt;
            ALU_OR:   f_o = a_i | b_i;
            ALU_AND:  f_o = a_i & b_i;
            default:  f_o = '0;
        endcase
    end
endmodule

// Arbiter top. NUM_REQ is meant to lie in 2..16.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  rv32i_types_pkg::ALU_op_enum req_op [NUM_REQ],
    input  logic [DATA_WIDTH-1:0]       req_a  [NUM_REQ],
    input  logic [DATA_WIDTH-1:0]       req_b  [NUM_REQ],
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [ID_WIDTH-1:0]         rsp_id,
    output logic [31:0]                 busy_cnt
);
    import rv32i_types_pkg::*;

    // One extra bit so that pointer + offset never overflows before the wrap.
    localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic [ID_WIDTH-1:0]   rsp_id_q,    rsp_id_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [31:0]           busy_cnt_q,  busy_cnt_d;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  grant_any;
    logic [ID_WIDTH:0]     scan_idx;
    logic [ID_WIDTH:0]     next_ptr_w;
    logic [ID_WIDTH-1:0]   next_ptr;

    logic                  can_accept;
    logic                  accept;

    ALU_op_enum            op_sel;
    logic [DATA_WIDTH-1:0] a_sel;
    logic [DATA_WIDTH-1:0] b_sel;
    logic [DATA_WIDTH-1:0] alu_f;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(off);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!grant_any && req_valid[scan_idx[ID_WIDTH-1:0]]) begin
                grant_any                       = 1'b1;
                grant_id                        = scan_idx[ID_WIDTH-1:0];
                grant[scan_idx[ID_WIDTH-1:0]]   = 1'b1;
            end
        end
    end

    // The pointer moves to the slot just past the requester being served.
    always_comb begin
        next_ptr_w = {1'b0, grant_id} + (ID_WIDTH+1)'(1);
        if (next_ptr_w >= NUM_REQ_W) begin
            next_ptr_w = '0;
        end
        next_ptr = next_ptr_w[ID_WIDTH-1:0];
    end

    // Output register is free when empty or being drained this cycle.
    // Reset masks every ready so nothing is accepted during the reset cycle.
    assign can_accept = !rsp_valid_q || rsp_ready;
    assign req_ready  = grant & {NUM_REQ{can_accept && !rst}};
    assign accept     = grant_any && can_accept && !rst;

    // One-hot operand mux; non-granted requesters cannot reach the ALU.
    always_comb begin
        op_sel = ALU_NONE;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                op_sel = req_op[i];
                a_sel  = req_a[i];
                b_sel  = req_b[i];
            end
        end
    end

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op_i (op_sel),
        .a_i  (a_sel),
        .b_i  (b_sel),
        .f_o  (alu_f)
    );

    // Next-state for the result register, pointer and activity counter.
    // Data and id keep their last value when the register drains.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rr_ptr_d    = rr_ptr_q;
        busy_cnt_d  = busy_cnt_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = alu_f;
            rsp_id_d    = grant_id;
            rr_ptr_d    = next_ptr;
            busy_cnt_d  = busy_cnt_q + 32'd1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
            busy_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy_cnt  = busy_cnt_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed sequences, an ALU vector table and a
// randomized run, all checked against a behavioural model of the arbiter.
module tb_alu_share_arbiter;
    import rv32i_types_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    ALU_op_enum        req_op [NR];
    logic [DW-1:0]     req_a  [NR];
    logic [DW-1:0]     req_b  [NR];
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic [IW-1:0]     rsp_id;
    logic [31:0]       busy_cnt;

    alu_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    int            m_id    = 0;
    int            m_ptr   = 0;
    logic [31:0]   m_cnt   = '0;
    logic [NR-1:0] last_ready;

    typedef struct {
        ALU_op_enum  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input ALU_op_enum op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $signed(a) >>> sh;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    // Winner = valid requester with the smallest cyclic distance from the pointer.
    function automatic int model_pick();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NR;
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i]) begin
                d = (i - m_ptr + NR) % NR;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // Called just after a rising edge (inputs already driven): checks ready,
    // advances the model through the next edge, then checks registered outputs.
    task automatic step(input string tag);
        int            g;
        logic [NR-1:0] exp_rdy;
        #1;
        g = model_pick();
        exp_rdy = '0;
        if (!rst && (!m_valid || rsp_ready) && g >= 0) exp_rdy[g] = 1'b1;
        last_ready = req_ready;
        chk({tag, ":ready"}, 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 0;
            m_ptr   = 0;
            m_cnt   = '0;
        end else if (exp_rdy != '0) begin
            m_valid = 1'b1;
            m_data  = ref_alu(req_op[g], req_a[g], req_b[g]);
            m_id    = g;
            m_ptr   = (g + 1) % NR;
            m_cnt   = m_cnt + 32'd1;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, ":rsp_valid"}, 64'(rsp_valid), 64'(m_valid));
        chk({tag, ":rsp_data"},  64'(rsp_data),  64'(m_data));
        chk({tag, ":rsp_id"},    64'(rsp_id),    64'(m_id));
        chk({tag, ":busy_cnt"},  64'(busy_cnt),  64'(m_cnt));
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            req_op[i] = ALU_NONE;
            req_a[i]  = '0;
            req_b[i]  = '0;
        end
    endtask

    logic [31:0] specials [6];

    initial begin
        vecs[0]  = '{ALU_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[1]  = '{ALU_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000};
        vecs[2]  = '{ALU_SLTU, 32'd1,          32'hFFFF_FFFF,  32'd1};
        vecs[3]  = '{ALU_ADD,  32'd5,          32'd7,          32'd12};
        vecs[4]  = '{ALU_SLL,  32'd1,          32'd31,         32'h8000_0000};
        vecs[5]  = '{ALU_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[6]  = '{ALU_SLT,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{ALU_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0};
        vecs[8]  = '{ALU_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[9]  = '{ALU_OR,   32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0};
        vecs[10] = '{ALU_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
        vecs[11] = '{ALU_NONE, 32'd5,          32'd7,          32'd0};
        vecs[12] = '{ALU_op_enum'(4'hF), 32'd5, 32'd7,         32'd0};
        vecs[13] = '{ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0};

        specials[0] = 32'h0;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000;
        specials[3] = 32'h7FFF_FFFF;
        specials[4] = 32'd1;
        specials[5] = 32'd31;

        clear_inputs();
        rst = 1'b1;
        req_valid = 4'b1111;
        @(posedge clk);
        step("reset0");
        step("reset1");

        // Single request
        rst = 1'b0;
        clear_inputs();
        req_valid = 4'b0001;
        req_op[0] = ALU_ADD;
        req_a[0]  = 32'd5;
        req_b[0]  = 32'd7;
        step("single");
        chk("single:ready_now", 64'(last_ready), 64'(4'b0001));
        chk("single:data12", 64'(rsp_data), 64'd12);
        chk("single:id0", 64'(rsp_id), 64'd0);
        chk("single:cnt1", 64'(busy_cnt), 64'd1);

        // Fairness from a fresh reset
        rst = 1'b1;
        step("fair_rst");
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) begin
            req_op[i] = ALU_ADD;
            req_a[i]  = 32'(i * 10);
            req_b[i]  = 32'(i);
        end
        for (int k = 0; k < 5; k++) begin
            step("fair");
            chk("fair:id_seq", 64'(rsp_id), 64'(k % NR));
            chk("fair:valid", 64'(rsp_valid), 64'd1);
        end

        // Backpressure with requester 1 waiting
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step("bp_hold");
            chk("bp:ready_low", 64'(last_ready), 64'd0);
            chk("bp:id_stable", 64'(rsp_id), 64'd0);
        end
        rsp_ready = 1'b1;
        step("bp_release");
        chk("bp:ready_r1", 64'(last_ready), 64'(4'b0010));
        chk("bp:id1", 64'(rsp_id), 64'd1);
        chk("bp:data11", 64'(rsp_data), 64'd11);

        // Reset mid-stream
        req_valid = 4'b1111;
        rst = 1'b1;
        step("mid_rst");
        chk("mid_rst:valid0", 64'(rsp_valid), 64'd0);
        chk("mid_rst:cnt0", 64'(busy_cnt), 64'd0);
        rst = 1'b0;
        step("post_rst");
        chk("post_rst:ready_r0", 64'(last_ready), 64'(4'b0001));
        chk("post_rst:id0", 64'(rsp_id), 64'd0);

        // ALU vector table via requester 2, with noise on the others
        for (int v = 0; v < 14; v++) begin
            for (int i = 0; i < NR; i++) begin
                req_op[i] = ALU_op_enum'(4'($urandom_range(0, 15)));
                req_a[i]  = $urandom();
                req_b[i]  = $urandom();
            end
            req_valid = 4'b0100;
            rsp_ready = 1'b1;
            req_op[2] = vecs[v].op;
            req_a[2]  = vecs[v].a;
            req_b[2]  = vecs[v].b;
            step("vec");
            chk($sformatf("vec%0d:data", v), 64'(rsp_data), 64'(vecs[v].exp));
            chk($sformatf("vec%0d:id", v), 64'(rsp_id), 64'd2);
        end

        // Counter wrap
        req_valid = 4'b0000;
        force dut.busy_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.busy_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        req_valid = 4'b0001;
        step("wrap");
        chk("wrap:cnt0", 64'(busy_cnt), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NR; i++) begin
                req_op[i] = ALU_op_enum'(4'($urandom_range(0, 15)));
                req_a[i]  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
                req_b[i]  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
            end
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one ALU; legal range 2..16.
REQ-003 SHALL have parameter ID_WIDTH, default $clog2(NUM_REQ), width of the requester index.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_op  input  NUM_REQ x rv32i_types_pkg::ALU_op_enum  per-requester operation.
REQ-009 req_a, req_b  input  NUM_REQ x DATA_WIDTH  per-requester operands.
REQ-010 rsp_valid  output  1  result register holds a valid result.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 rsp_data  output  DATA_WIDTH  registered ALU result.
REQ-013 rsp_id  output  ID_WIDTH  index of the requester that produced rsp_data.
REQ-014 busy_cnt  output  32  count of cycles in which a request was accepted.

Function
REQ-015 SHALL instantiate exactly one ALU (DATA_WIDTH passed through); op/A/B driven by a mux selected by the current grant.
REQ-016 SHALL define can_accept = !rsp_valid || rsp_ready (result register empty or draining this cycle).
REQ-017 SHALL compute grant combinationally: round-robin over req_valid, search starting at pointer rr_ptr, increasing index, wrapping NUM_REQ-1 -> 0.
REQ-018 req_ready[i] SHALL equal grant[i] && can_accept; all req_ready low when no req_valid or !can_accept.
REQ-019 req_ready MAY depend on req_valid; requesters SHALL NOT make req_valid depend on req_ready.
REQ-020 Accept = req_valid[i] && req_ready[i]; on accept, at next edge: rsp_valid=1, rsp_data=ALU result of requester i's op/A/B, rsp_id=i, rr_ptr=(i+1) mod NUM_REQ.
REQ-021 Latency SHALL be exactly 1 cycle from accept to rsp_valid; throughput 1 result/cycle when rsp_ready held high.
REQ-022 If rsp_valid && !rsp_ready: rsp_valid, rsp_data, rsp_id SHALL hold stable; no accept occurs; rr_ptr holds.
REQ-023 If rsp_valid && rsp_ready and no accept this cycle: rsp_valid SHALL go 0 next cycle; rsp_data/rsp_id hold last value.
REQ-024 Simultaneous drain and accept SHALL load the new result with rsp_valid remaining 1 (no bubble).
REQ-025 rr_ptr SHALL change only on an accept; unserved requests keep their position.
REQ-026 A requester with req_valid held high SHALL be granted within NUM_REQ accepts (no starvation).
REQ-027 busy_cnt SHALL increment by 1 on every accept, wrapping 2^32-1 -> 0.
REQ-028 Operations ALU_NONE and unknown encodings SHALL still be accepted and produce rsp_data=0.
REQ-029 Request inputs of non-granted requesters SHALL have no effect on any output.

Reset
REQ-030 While rst=1 at a rising edge: rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, busy_cnt=0.
REQ-031 While rst=1, req_ready SHALL be all zero; no accept occurs in that cycle.
REQ-032 Reset mid-operation SHALL discard any pending result; first grant after reset goes to lowest valid index.

Verification
REQ-033 Single request: req_valid=0001, op=ALU_ADD, A=5, B=7, rsp_ready=1 -> req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_data=12, rsp_id=0; busy_cnt=1.
REQ-034 Fairness: req_valid=1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 on consecutive cycles, rsp_valid continuous.
REQ-035 Backpressure: result pending, rsp_ready=0 for 3 cycles with req_valid=0010 -> req_ready=0000, rsp_data/rsp_id stable; rsp_ready=1 -> requester 1 accepted same cycle, its result next cycle.
REQ-036 Operation check via requester 2: ALU_SUB A=3 B=5 -> 0xFFFFFFFE; ALU_SRA A=0x80000000 B=4 -> 0xF8000000; ALU_SLTU A=1 B=0xFFFFFFFF -> 1.
REQ-037 Reset mid-stream: rst=1 one cycle while rsp_valid=1, req_valid=1111 -> rsp_valid=0, busy_cnt=0 after edge; next grant to requester 0.
REQ-038 Counter wrap: force busy_cnt=0xFFFFFFFF then one accept -> busy_cnt=0.
